// File: rtl/tinyqv_intc.sv
// Nibble-serial interrupt controller for TinyQV: mie/mip/mcause/mtrig CSRs,
// per-channel edge/level mode, priority resolution and claim handling.
module tinyqv_intc #(
    parameter int          NUM_IRQ    = 16,
    parameter logic [15:0] EDGE_RESET = 16'h0003
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         counter,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [3:0]         csr_wdata,
    output logic [3:0]         csr_rdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               timer_irq,
    input  logic               global_ie,
    input  logic               take_interrupt,
    output logic               interrupt_pending,
    output logic [5:0]         mcause_out
);

    localparam logic [11:0] ADDR_MIE    = 12'h304;
    localparam logic [11:0] ADDR_MIP    = 12'h344;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] ADDR_MTRIG  = 12'h7C0;

    logic               mie_timer_reg, mie_timer_next;
    logic [NUM_IRQ-1:0] mie_ch_reg, mie_ch_next;
    logic [NUM_IRQ-1:0] edge_mode_reg, edge_mode_next;
    logic [NUM_IRQ-1:0] latch_reg, latch_next;
    logic [NUM_IRQ-1:0] irq_s_reg, irq_l_reg;
    logic [5:0]         mcause_reg, mcause_next;

    logic [NUM_IRQ-1:0] mip_ch, irq_edge, pend_ch, clr_sel, claim_clr;
    logic [31:0]        mie32, mip32, mtrig32, mcause32, rd_sel32;
    logic [3:0]         old_nib, new_nib;
    logic [4:0]         win_code;
    logic               win_found, timer_act, claim;
    logic               wr_mie, wr_mip, wr_mtrig;

    assign irq_edge = irq_s_reg & ~irq_l_reg;
    // Level channels report the synchronised line; the latch is only live in edge mode.
    assign mip_ch   = (edge_mode_reg & latch_reg) | (~edge_mode_reg & irq_s_reg);
    assign pend_ch  = mip_ch & mie_ch_reg;
    assign timer_act = timer_irq && mie_timer_reg;
    assign interrupt_pending = global_ie && (timer_act || (|pend_ch));
    assign mcause_out = mcause_reg;

    always_comb begin
        mie32   = '0;
        mip32   = '0;
        mtrig32 = '0;
        mie32[7] = mie_timer_reg;
        mip32[7] = timer_irq;
        for (int i = 0; i < NUM_IRQ; i++) begin
            mie32[16+i]   = mie_ch_reg[i];
            mip32[16+i]   = mip_ch[i];
            mtrig32[16+i] = edge_mode_reg[i];
        end
    end

    assign mcause32 = {mcause_reg[5], 26'b0, mcause_reg[4:0]};

    always_comb begin
        case (csr_addr)
            ADDR_MIE:    rd_sel32 = mie32;
            ADDR_MIP:    rd_sel32 = mip32;
            ADDR_MCAUSE: rd_sel32 = mcause32;
            ADDR_MTRIG:  rd_sel32 = mtrig32;
            default:     rd_sel32 = '0;
        endcase
    end

    assign old_nib   = rd_sel32[{counter, 2'b00} +: 4];
    assign csr_rdata = old_nib;

    always_comb begin
        case (csr_op)
            2'b01:   new_nib = csr_wdata;
            2'b10:   new_nib = old_nib | csr_wdata;
            2'b11:   new_nib = old_nib & ~csr_wdata;
            default: new_nib = old_nib;
        endcase
    end

    assign wr_mie   = (csr_op != 2'b00) && (csr_addr == ADDR_MIE);
    assign wr_mip   = (csr_op != 2'b00) && (csr_addr == ADDR_MIP);
    assign wr_mtrig = (csr_op != 2'b00) && (csr_addr == ADDR_MTRIG);

    assign mie_timer_next = (wr_mie && counter == 3'd1) ? new_nib[3] : mie_timer_reg;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
            localparam logic [2:0] NIB = 3'(4 + gi / 4);
            localparam int         BIT = gi % 4;
            assign mie_ch_next[gi] = (wr_mie && counter == NIB) ? new_nib[BIT] : mie_ch_reg[gi];
            assign edge_mode_next[gi] = (wr_mtrig && counter == NIB) ? new_nib[BIT] : edge_mode_reg[gi];
            // Hardware edge ORs in last so it beats a same-cycle software or claim clear;
            // any mode change (either direction) leaves the latch empty.
            assign latch_next[gi] = (((wr_mip && counter == NIB) ? new_nib[BIT]
                                       : (latch_reg[gi] & ~claim_clr[gi])) | irq_edge[gi])
                                    & edge_mode_reg[gi] & edge_mode_next[gi];
        end
    endgenerate

    // Lowest index wins: scan downward so the last hit is the smallest channel.
    always_comb begin
        win_found = 1'b0;
        win_code  = 5'h10;
        clr_sel   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_ch[i]) begin
                win_found  = 1'b1;
                win_code   = 5'(16 + i);
                clr_sel    = '0;
                clr_sel[i] = 1'b1;
            end
        end
    end

    assign claim = take_interrupt && (counter == 3'd0);

    always_comb begin
        mcause_next = mcause_reg;
        claim_clr   = '0;
        if (claim) begin
            if (timer_act) begin
                mcause_next = {1'b1, 5'h07};
            end else if (win_found) begin
                mcause_next = {1'b1, win_code};
                claim_clr   = clr_sel & edge_mode_reg;
            end else begin
                mcause_next = {1'b1, 5'h10};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_timer_reg <= 1'b0;
            mie_ch_reg    <= '0;
            edge_mode_reg <= EDGE_RESET[NUM_IRQ-1:0];
            latch_reg     <= '0;
            irq_s_reg     <= '0;
            irq_l_reg     <= '0;
            mcause_reg    <= '0;
        end else begin
            mie_timer_reg <= mie_timer_next;
            mie_ch_reg    <= mie_ch_next;
            edge_mode_reg <= edge_mode_next;
            latch_reg     <= latch_next;
            irq_s_reg     <= irq_in;
            irq_l_reg     <= irq_s_reg;
            mcause_reg    <= mcause_next;
        end
    end

endmodule

// File: tb/tb_tinyqv_intc.sv
// Directed self-checking bench for tinyqv_intc (16-channel and 4-channel builds).
module tb_tinyqv_intc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  counter = 3'd0;
    logic [11:0] csr_addr = 12'h000;
    logic [1:0]  csr_op = 2'b00;
    logic [3:0]  csr_wdata = 4'h0;
    logic [3:0]  csr_rdata, rdata4;
    logic [15:0] irq_in = 16'h0000;
    logic        timer_irq = 1'b0;
    logic        global_ie = 1'b0;
    logic        take_interrupt = 1'b0;
    logic        interrupt_pending, pend4;
    logic [5:0]  mcause_out, mcause4;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tinyqv_intc #(.NUM_IRQ(16), .EDGE_RESET(16'h0003)) dut (
        .clk(clk), .rst(rst), .counter(counter), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .irq_in(irq_in), .timer_irq(timer_irq), .global_ie(global_ie),
        .take_interrupt(take_interrupt), .interrupt_pending(interrupt_pending),
        .mcause_out(mcause_out)
    );

    tinyqv_intc #(.NUM_IRQ(4), .EDGE_RESET(16'h0003)) dut4 (
        .clk(clk), .rst(rst), .counter(counter), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(rdata4),
        .irq_in(irq_in[3:0]), .timer_irq(timer_irq), .global_ie(global_ie),
        .take_interrupt(take_interrupt), .interrupt_pending(pend4),
        .mcause_out(mcause4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 3'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #1;
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [31:0] rd4);
        while (counter != 3'd0) tick();
        for (int k = 0; k < 8; k++) begin
            csr_addr  = a;
            csr_op    = op;
            csr_wdata = wd[4*k +: 4];
            #1;
            rd[4*k +: 4]  = csr_rdata;
            rd4[4*k +: 4] = rdata4;
            tick();
        end
        csr_op    = 2'b00;
        csr_wdata = 4'h0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] r, r4;
        csr(a, op, wd, r, r4);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] r, r4;
        csr(a, 2'b00, 32'h0, r, r4);
        check(tag, r, exp);
    endtask

    task automatic rd_chk4(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] r, r4;
        csr(a, 2'b00, 32'h0, r, r4);
        check(tag, r4, exp);
    endtask

    task automatic do_claim();
        while (counter != 3'd0) tick();
        take_interrupt = 1'b1;
        tick();
        take_interrupt = 1'b0;
    endtask

    initial begin
        // Power-on reset, then reset landing in the middle of an mie write
        repeat (3) tick();
        rst = 1'b0;
        tick();
        while (counter != 3'd0) tick();
        for (int k = 0; k < 8; k++) begin
            csr_addr = 12'h304; csr_op = 2'b01; csr_wdata = 4'hF;
            if (k == 3) rst = 1'b1;
            tick();
        end
        csr_op = 2'b00;
        rst = 1'b0;
        tick();
        rd_chk("rst_mie", 12'h304, 32'h0000_0000);
        rd_chk("rst_mip", 12'h344, 32'h0000_0000);
        rd_chk("rst_mtrig", 12'h7C0, 32'h0003_0000);
        rd_chk4("rst_mtrig4", 12'h7C0, 32'h0003_0000);
        check("rst_pend", 32'(interrupt_pending), 32'h0);
        check("rst_mcause", 32'(mcause_out), 32'h0);

        // Edge latch on channel 0
        global_ie = 1'b1;
        wr(12'h304, 2'b01, 32'h0001_0000);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        check("edge_pend_early", 32'(interrupt_pending), 32'h0);
        tick();
        check("edge_pend", 32'(interrupt_pending), 32'h1);
        do_claim();
        check("edge_mcause", 32'(mcause_out), 32'h30);
        check("edge_pend_clr", 32'(interrupt_pending), 32'h0);
        rd_chk("edge_mip_clr", 12'h344, 32'h0000_0000);

        // Level channel 5
        wr(12'h304, 2'b01, 32'h0020_0000);
        irq_in[5] = 1'b1;
        tick();
        check("lvl_pend", 32'(interrupt_pending), 32'h1);
        do_claim();
        check("lvl_mcause", 32'(mcause_out), 32'h35);
        check("lvl_pend_held", 32'(interrupt_pending), 32'h1);
        wr(12'h344, 2'b11, 32'h0020_0000);
        rd_chk("lvl_mip_ro", 12'h344, 32'h0020_0000);
        irq_in[5] = 1'b0;
        tick();
        check("lvl_pend_drop", 32'(interrupt_pending), 32'h0);

        // Priority: timer, then channel 2, then channel 9
        wr(12'h304, 2'b01, 32'h0204_0080);
        timer_irq = 1'b1; irq_in[2] = 1'b1; irq_in[9] = 1'b1;
        tick();
        do_claim();
        check("prio_timer", 32'(mcause_out), 32'h27);
        timer_irq = 1'b0;
        do_claim();
        check("prio_ch2", 32'(mcause_out), 32'h32);
        irq_in[2] = 1'b0;
        tick();
        do_claim();
        check("prio_ch9", 32'(mcause_out), 32'h39);
        irq_in[9] = 1'b0;
        tick();

        // New edge on channel 1 coinciding with its claim
        wr(12'h304, 2'b01, 32'h0002_0000);
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        tick();
        tick();
        check("coll_latched", 32'(interrupt_pending), 32'h1);
        while (counter != 3'd7) tick();
        irq_in[1] = 1'b1;
        tick();
        take_interrupt = 1'b1;
        tick();
        take_interrupt = 1'b0;
        irq_in[1] = 1'b0;
        check("coll_mcause", 32'(mcause_out), 32'h31);
        rd_chk("coll_mip", 12'h344, 32'h0002_0000);
        wr(12'h344, 2'b11, 32'h0002_0000);
        rd_chk("sw_clear_mip", 12'h344, 32'h0000_0000);
        check("sw_clear_pend", 32'(interrupt_pending), 32'h0);
        wr(12'h344, 2'b10, 32'h0002_0000);
        rd_chk("sw_set_mip", 12'h344, 32'h0002_0000);
        check("sw_set_pend", 32'(interrupt_pending), 32'h1);
        wr(12'h344, 2'b01, 32'h0000_0000);

        // Claim with nothing enabled and pending
        wr(12'h304, 2'b01, 32'h0000_0000);
        do_claim();
        check("empty_claim", 32'(mcause_out), 32'h30);

        // Mode switch on channel 0
        wr(12'h304, 2'b01, 32'h0001_0000);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick();
        tick();
        rd_chk("mode_latched", 12'h344, 32'h0001_0000);
        wr(12'h7C0, 2'b01, 32'h0002_0000);
        rd_chk("mode_mtrig", 12'h7C0, 32'h0002_0000);
        rd_chk("mode_lvl_low", 12'h344, 32'h0000_0000);
        irq_in[0] = 1'b1;
        tick();
        rd_chk("mode_lvl_high", 12'h344, 32'h0001_0000);
        wr(12'h7C0, 2'b01, 32'h0003_0000);
        rd_chk("mode_edge_noedge", 12'h344, 32'h0000_0000);
        irq_in[0] = 1'b0;
        tick();

        // Channels beyond NUM_IRQ read zero
        wr(12'h304, 2'b01, 32'hFFFF_0000);
        rd_chk("mie_16ch", 12'h304, 32'hFFFF_0000);
        rd_chk4("mie_4ch", 12'h304, 32'h000F_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
